// File: rtl/vga_scene_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vga_scene_scheduler
// Description : Frame-synchronous scene sequencer for the VGA demo datapath.
//               Each scene fades in, holds at full brightness, fades out to
//               black and then switches to the next scene (auto-increment or
//               CPU-selected). All sequencing advances only on frame_start,
//               the start-of-vertical-blank pulse from vga_demo.
//
// Ports       : clk              - system clock
//               reset            - synchronous, active-high reset
//               frame_start      - one-cycle pulse at start of vertical blank
//               hold_frames      - frames held at full brightness (0 = forever)
//               fade_step_frames - frames per brightness step (0 acts as 1)
//               manual_en        - 1: next scene comes from manual_scene
//               manual_scene     - requested next scene
//               manual_go        - one-cycle request to leave the scene early
//               scene            - current scene index
//               brightness       - global intensity, 0 = black, 15 = full
//               scene_change     - one-cycle pulse when scene updates
//               state            - 0 FADE_IN, 1 HOLD, 2 FADE_OUT, 3 SWITCH
//
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scene_scheduler #(
    parameter int NUM_SCENES = 4,
    parameter int SCENE_W    = 2,
    parameter int HOLD_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [HOLD_W-1:0]  hold_frames,
    input  logic [3:0]         fade_step_frames,
    input  logic               manual_en,
    input  logic [SCENE_W-1:0] manual_scene,
    input  logic               manual_go,
    output logic [SCENE_W-1:0] scene,
    output logic [3:0]         brightness,
    output logic               scene_change,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_FADE_IN  = 2'd0,
        ST_HOLD     = 2'd1,
        ST_FADE_OUT = 2'd2,
        ST_SWITCH   = 2'd3
    } state_t;

    // One extra bit so NUM_SCENES itself is representable for the range test.
    localparam logic [SCENE_W:0]   c_num_scenes = (SCENE_W+1)'(NUM_SCENES);
    localparam logic [SCENE_W-1:0] c_last_scene = SCENE_W'(NUM_SCENES - 1);

    state_t              r_state;
    logic [SCENE_W-1:0]  r_scene;
    logic [3:0]          r_bright;
    logic                r_change;
    logic [3:0]          r_step;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_go_pending;

    state_t              w_nxt_state;
    logic [SCENE_W-1:0]  w_nxt_scene;
    logic [3:0]          w_nxt_bright;
    logic                w_nxt_change;
    logic [3:0]          w_nxt_step;
    logic [HOLD_W-1:0]   w_nxt_hold;
    logic                w_nxt_go;

    logic [3:0]          w_step_eff;
    logic                w_step_done;
    logic                w_go_active;
    logic [3:0]          w_bright_inc;
    logic [3:0]          w_bright_dec;
    logic [SCENE_W-1:0]  w_manual_pick;
    logic [SCENE_W-1:0]  w_scene_inc;
    logic [SCENE_W-1:0]  w_next_scene;

    assign w_step_eff  = (fade_step_frames == 4'd0) ? 4'd1 : fade_step_frames;
    assign w_step_done = (r_step == (w_step_eff - 4'd1));
    // A go pulse landing on the frame_start cycle acts on that same frame.
    assign w_go_active = r_go_pending | (manual_go & frame_start);

    // Saturating brightness steps: never wrap past 15 or below 0.
    assign w_bright_inc = (r_bright == 4'd15) ? 4'd15 : r_bright + 4'd1;
    assign w_bright_dec = (r_bright == 4'd0)  ? 4'd0  : r_bright - 4'd1;

    // Out-of-range manual requests fall back to scene 0.
    assign w_manual_pick = ({1'b0, manual_scene} < c_num_scenes) ? manual_scene : '0;
    assign w_scene_inc   = (r_scene == c_last_scene) ? '0 : r_scene + SCENE_W'(1);
    assign w_next_scene  = manual_en ? w_manual_pick : w_scene_inc;

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_scene  = r_scene;
        w_nxt_bright = r_bright;
        w_nxt_change = 1'b0;
        w_nxt_step   = r_step;
        w_nxt_hold   = r_hold;
        w_nxt_go     = r_go_pending;

        // Go requests are only remembered while a scene is still showing.
        if (manual_go && ((r_state == ST_FADE_IN) || (r_state == ST_HOLD))) begin
            w_nxt_go = 1'b1;
        end

        if (frame_start) begin
            unique case (r_state)
                ST_FADE_IN: begin
                    if (w_go_active && (r_bright != 4'd15)) begin
                        w_nxt_state = ST_FADE_OUT;
                        w_nxt_step  = 4'd0;
                        w_nxt_go    = 1'b0;
                    end else if (w_step_done) begin
                        w_nxt_step   = 4'd0;
                        w_nxt_bright = w_bright_inc;
                        if (w_bright_inc == 4'd15) begin
                            w_nxt_state = ST_HOLD;
                            w_nxt_hold  = '0;
                        end
                    end else begin
                        w_nxt_step = r_step + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_go_active) begin
                        w_nxt_state = ST_FADE_OUT;
                        w_nxt_step  = 4'd0;
                        w_nxt_go    = 1'b0;
                    end else if (hold_frames == '0) begin
                        w_nxt_state = ST_HOLD;
                    end else if (r_hold == (hold_frames - HOLD_W'(1))) begin
                        w_nxt_state = ST_FADE_OUT;
                        w_nxt_step  = 4'd0;
                        w_nxt_go    = 1'b0;
                    end else begin
                        w_nxt_hold = r_hold + HOLD_W'(1);
                    end
                end
                ST_FADE_OUT: begin
                    if (w_step_done) begin
                        w_nxt_step   = 4'd0;
                        w_nxt_bright = w_bright_dec;
                        if (w_bright_dec == 4'd0) begin
                            w_nxt_state = ST_SWITCH;
                        end
                    end else begin
                        w_nxt_step = r_step + 4'd1;
                    end
                end
                ST_SWITCH: begin
                    w_nxt_scene  = w_next_scene;
                    w_nxt_change = 1'b1;
                    w_nxt_state  = ST_FADE_IN;
                    w_nxt_step   = 4'd0;
                end
                default: begin
                    w_nxt_state = ST_FADE_IN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FADE_IN;
            r_scene      <= '0;
            r_bright     <= 4'd0;
            r_change     <= 1'b0;
            r_step       <= 4'd0;
            r_hold       <= '0;
            r_go_pending <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_scene      <= w_nxt_scene;
            r_bright     <= w_nxt_bright;
            r_change     <= w_nxt_change;
            r_step       <= w_nxt_step;
            r_hold       <= w_nxt_hold;
            r_go_pending <= w_nxt_go;
        end
    end

    assign scene        = r_scene;
    assign brightness   = r_bright;
    assign scene_change = r_change;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vga_scene_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scene_scheduler
// Description : Self-checking bench for vga_scene_scheduler. Two instances
//               (4 and 3 scenes) share all inputs; a frame-level reference
//               model runs beside them. Directed table, hand sequences for
//               the corner cases, then randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scene_scheduler;

    localparam int P_IN   = 0;
    localparam int P_HOLD = 1;
    localparam int P_OUT  = 2;
    localparam int P_SW   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic [7:0] hold_frames = 8'd2;
    logic [3:0] fade_step_frames = 4'd1;
    logic       manual_en = 1'b0;
    logic [1:0] manual_scene = 2'd0;
    logic       manual_go = 1'b0;

    logic [1:0] scene4, state4, scene3, state3;
    logic [3:0] bright4, bright3;
    logic       chg4, chg3;

    always #5 clk = ~clk;

    vga_scene_scheduler #(.NUM_SCENES(4), .SCENE_W(2), .HOLD_W(8)) u_dut4 (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .hold_frames(hold_frames), .fade_step_frames(fade_step_frames),
        .manual_en(manual_en), .manual_scene(manual_scene), .manual_go(manual_go),
        .scene(scene4), .brightness(bright4), .scene_change(chg4), .state(state4)
    );

    vga_scene_scheduler #(.NUM_SCENES(3), .SCENE_W(2), .HOLD_W(8)) u_dut3 (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .hold_frames(hold_frames), .fade_step_frames(fade_step_frames),
        .manual_en(manual_en), .manual_scene(manual_scene), .manual_go(manual_go),
        .scene(scene3), .brightness(bright3), .scene_change(chg3), .state(state3)
    );

    // ---------------- reference model (one call per clock) ----------------
    typedef struct {
        int scene; int bright; int phase; int step; int hold; int pend; int chg;
    } mst_t;

    function automatic mst_t mreset();
        mst_t s;
        s.scene = 0; s.bright = 0; s.phase = P_IN; s.step = 0;
        s.hold = 0; s.pend = 0; s.chg = 0;
        return s;
    endfunction

    function automatic mst_t mstep(mst_t s, int nsc);
        mst_t n;
        int   se;
        bit   go_now;
        if (reset) return mreset();
        n = s;
        n.chg = 0;
        if (manual_go && (s.phase == P_IN || s.phase == P_HOLD)) n.pend = 1;
        if (!frame_start) return n;
        se = (fade_step_frames == 0) ? 1 : int'(fade_step_frames);
        go_now = (s.pend != 0) || manual_go;
        if (s.phase == P_IN) begin
            if (go_now && s.bright < 15) begin
                n.phase = P_OUT; n.step = 0; n.pend = 0;
            end else if (s.step == se - 1) begin
                n.step = 0;
                n.bright = (s.bright + 1 > 15) ? 15 : s.bright + 1;
                if (n.bright == 15) begin n.phase = P_HOLD; n.hold = 0; end
            end else n.step = (s.step + 1) % 16;
        end else if (s.phase == P_HOLD) begin
            if (go_now || (hold_frames != 0 && s.hold == int'(hold_frames) - 1)) begin
                n.phase = P_OUT; n.step = 0; n.pend = 0;
            end else if (hold_frames != 0) n.hold = (s.hold + 1) % 256;
        end else if (s.phase == P_OUT) begin
            if (s.step == se - 1) begin
                n.step = 0;
                n.bright = (s.bright - 1 < 0) ? 0 : s.bright - 1;
                if (n.bright == 0) n.phase = P_SW;
            end else n.step = (s.step + 1) % 16;
        end else begin
            if (manual_en) n.scene = (int'(manual_scene) < nsc) ? int'(manual_scene) : 0;
            else           n.scene = (s.scene + 1) % nsc;
            n.chg = 1; n.phase = P_IN; n.step = 0;
        end
        return n;
    endfunction

    mst_t m4, m3;
    always @(posedge clk) begin
        m4 <= mstep(m4, 4);
        m3 <= mstep(m3, 3);
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int failures = 0;
    bit mchk = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        chk("model4.scene",  int'(scene4),  m4.scene);
        chk("model4.bright", int'(bright4), m4.bright);
        chk("model4.chg",    int'(chg4),    m4.chg);
        chk("model4.state",  int'(state4),  m4.phase);
        chk("model3.scene",  int'(scene3),  m3.scene);
        chk("model3.bright", int'(bright3), m3.bright);
        chk("model3.chg",    int'(chg3),    m3.chg);
        chk("model3.state",  int'(state3),  m3.phase);
    endtask

    // Drive one clock: inputs change at a negedge, outputs sampled at the next.
    task automatic cyc(input bit fs, input bit go);
        frame_start = fs;
        manual_go   = go;
        @(negedge clk);
        frame_start = 1'b0;
        manual_go   = 1'b0;
        if (mchk) model_cmp();
    endtask

    task automatic frame(input bit go);
        cyc(1'b1, go);
        cyc(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic chk4(input string tag, input int sc, input int br, input int st);
        chk({tag, ".scene"},  int'(scene4),  sc);
        chk({tag, ".bright"}, int'(bright4), br);
        chk({tag, ".state"},  int'(state4),  st);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit rst; bit fs; bit go;
        int sc; int br; int ch; int st;
    } vec_t;

    function automatic vec_t mkv(bit rst, bit fs, bit go, int sc, int br, int ch, int st);
        vec_t v;
        v.rst = rst; v.fs = fs; v.go = go;
        v.sc = sc; v.br = br; v.ch = ch; v.st = st;
        return v;
    endfunction

    vec_t tv[$];
    int   pulses;
    int   seen[$];

    initial begin
        // step=1, hold=2, auto: 15 up, 2 held, 15 down, 1 switch = 33 frames.
        tv.push_back(mkv(1, 1, 0, 0, 0, 0, P_IN));
        for (int k = 1; k <= 33; k++) begin
            int sc, br, ch, st;
            sc = 0; ch = 0;
            if (k <= 15)      begin br = k;       st = (k == 15) ? P_HOLD : P_IN; end
            else if (k == 16) begin br = 15;      st = P_HOLD; end
            else if (k == 17) begin br = 15;      st = P_OUT; end
            else if (k <= 32) begin br = 32 - k;  st = (k == 32) ? P_SW : P_OUT; end
            else              begin br = 0; st = P_IN; sc = 1; ch = 1; end
            tv.push_back(mkv(0, 1, 0, sc, br, ch, st));
            tv.push_back(mkv(0, 0, 0, sc, br, 0, st));
        end

        @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            reset = tv[i].rst;
            cyc(tv[i].fs, tv[i].go);
            reset = 1'b0;
            chk($sformatf("table[%0d].scene", i),  int'(scene4),  tv[i].sc);
            chk($sformatf("table[%0d].bright", i), int'(bright4), tv[i].br);
            chk($sformatf("table[%0d].chg", i),    int'(chg4),    tv[i].ch);
            chk($sformatf("table[%0d].state", i),  int'(state4),  tv[i].st);
            mchk = 1'b1;
        end

        // Auto wrap over four full scene cycles.
        do_reset();
        pulses = 0;
        for (int f = 0; f < 4 * 33; f++) begin
            cyc(1'b1, 1'b0);
            if (chg4) begin pulses++; seen.push_back(int'(scene4)); end
            cyc(1'b0, 1'b0);
        end
        chk("wrap.pulses", pulses, 4);
        for (int i = 0; i < seen.size() && i < 4; i++)
            chk($sformatf("wrap.seq[%0d]", i), seen[i], (i + 1) % 4);
        chk("wrap.final4", int'(scene4), 0);
        chk("wrap.final3", int'(scene3), 1);

        // Slow fade: step=3 reaches full after 45 frames.
        hold_frames = 8'd0; fade_step_frames = 4'd3;
        do_reset();
        repeat (44) frame(1'b0);
        chk4("step3.f44", 0, 14, P_IN);
        frame(1'b0);
        chk4("step3.f45", 0, 15, P_HOLD);

        // step=0 acts as step=1.
        fade_step_frames = 4'd0;
        do_reset();
        repeat (14) frame(1'b0);
        chk4("step0.f14", 0, 14, P_IN);
        frame(1'b0);
        chk4("step0.f15", 0, 15, P_HOLD);

        // hold=0 holds forever until a go request.
        repeat (100) frame(1'b0);
        chk4("hold0.f100", 0, 15, P_HOLD);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk4("hold0.go_wait", 0, 15, P_HOLD);
        frame(1'b0);
        chk4("hold0.go_taken", 0, 15, P_OUT);
        repeat (15) frame(1'b0);
        chk4("hold0.dark", 0, 0, P_SW);
        manual_en = 1'b1; manual_scene = 2'd2;
        frame(1'b0);
        chk4("manual2.d4", 2, 0, P_IN);
        chk("manual2.d3", int'(scene3), 2);
        repeat (15) frame(1'b0);
        frame(1'b1);
        chk4("manual.go_coincident", 2, 15, P_OUT);
        repeat (15) frame(1'b0);
        manual_scene = 2'd3;
        cyc(1'b1, 1'b0);
        chk("manual3.scene4", int'(scene4), 3);
        chk("manual3.chg4",   int'(chg4),   1);
        chk("range.scene3",   int'(scene3), 0);
        chk("range.chg3",     int'(chg3),   1);
        cyc(1'b0, 1'b0);
        chk("manual3.chg4_clear", int'(chg4), 0);

        // Early go in FADE_IN; go ignored in FADE_OUT and SWITCH.
        manual_en = 1'b0; fade_step_frames = 4'd1;
        do_reset();
        repeat (7) frame(1'b0);
        chk4("early.b7", 0, 7, P_IN);
        frame(1'b1);
        chk4("early.go", 0, 7, P_OUT);
        frame(1'b0);
        chk4("early.b6", 0, 6, P_OUT);
        cyc(1'b0, 1'b1);
        frame(1'b0);
        chk4("early.go_in_out", 0, 5, P_OUT);
        repeat (5) frame(1'b0);
        chk4("early.dark", 0, 0, P_SW);
        frame(1'b1);
        chk4("early.go_in_switch", 1, 0, P_IN);
        frame(1'b0);
        chk4("early.no_pending", 1, 1, P_IN);

        // Reset mid-FADE_OUT together with frame_start.
        manual_en = 1'b1; manual_scene = 2'd2; hold_frames = 8'd1;
        do_reset();
        repeat (32) frame(1'b0);
        chk4("midreset.scene2", 2, 0, P_IN);
        repeat (22) frame(1'b0);
        chk4("midreset.pre", 2, 9, P_OUT);
        reset = 1'b1;
        cyc(1'b1, 1'b0);
        reset = 1'b0;
        chk4("midreset.post", 0, 0, P_IN);
        chk("midreset.chg", int'(chg4), 0);
        cyc(1'b0, 1'b0);
        chk4("midreset.idle", 0, 0, P_IN);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                hold_frames      = 8'($urandom_range(0, 4));
                fade_step_frames = 4'($urandom_range(0, 3));
                manual_en        = 1'($urandom_range(0, 1));
                manual_scene     = 2'($urandom_range(0, 3));
            end
            reset = ($urandom_range(0, 999) == 0);
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
